// File: rtl/weight_addr_gen.sv
// Weight-memory address generator: streams a TILE x TILE block of weight
// addresses over a valid/ready handshake, then pulses done for one cycle.
//
// Parameters:
//   ROW_STRIDE  words per weight row (row pitch)
//   DEPTH       weight memory depth in words, AW = $clog2(DEPTH)
//   TILE        tile edge length (>= 2), TW = $clog2(TILE)
//   IDX_W       width of the tile index inputs
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        begin a tile (sampled only in IDLE)
//   i, j, k      tile indices, latched when start is accepted
//   transpose    column-fast walk select (only with WADDR_TRANSPOSE_EN)
//   addr_ready   consumer accepts the current address
//   addr_valid   addr is valid
//   addr         weight address (truncated to AW bits)
//   last         current beat is the final beat of the tile
//   busy         high while streaming
//   done         one-cycle pulse after the final handshake
//   err          sticky out-of-range flag, cleared by the next start
// Build option:
//   WADDR_TRANSPOSE_EN  adds the transpose port and the column-fast walk

module weight_addr_gen #(
    parameter int ROW_STRIDE = 16,
    parameter int DEPTH      = 32,
    parameter int TILE       = 4,
    parameter int IDX_W      = 8,
    localparam int AW        = $clog2(DEPTH),
    localparam int TW        = $clog2(TILE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] i,
    input  logic [IDX_W-1:0] j,
    input  logic [IDX_W-1:0] k,
`ifdef WADDR_TRANSPOSE_EN
    input  logic             transpose,
`endif
    input  logic             addr_ready,
    output logic             addr_valid,
    output logic [AW-1:0]    addr,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0]   RS   = 32'(ROW_STRIDE);
    localparam logic [31:0]   TL   = 32'(TILE);
    localparam logic [31:0]   DP   = 32'(DEPTH);
    localparam logic [TW-1:0] TMAX = TW'(TILE - 1);

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   base_q;
    logic [31:0]   base_d;
    logic [31:0]   offs;
    logic [31:0]   full;
    logic [TW-1:0] r_q;
    logic [TW-1:0] c_q;
    logic          err_q;
    logic          accept;
    logic          hs;
    logic          r_end;
    logic          c_end;
    logic          oor;
`ifdef WADDR_TRANSPOSE_EN
    logic          tr_q;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        addr_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                addr_valid = 1'b1;
                busy       = 1'b1;
                if (addr_ready && r_end && c_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept = (state_q == IDLE) && start;
    assign hs     = addr_valid && addr_ready;
    assign r_end  = (r_q == TMAX);
    assign c_end  = (c_q == TMAX);

    // Base is formed once per tile, in 32 bits, so overflow of the
    // memory range is still visible to the range check.
    assign base_d = RS * TL * 32'(i) * 32'(k) + TL * 32'(j);

`ifdef WADDR_TRANSPOSE_EN
    always_comb begin
        offs = RS * 32'(r_q) + 32'(c_q);
        if (tr_q) begin
            offs = RS * 32'(c_q) + 32'(r_q);
        end
    end
`else
    assign offs = RS * 32'(r_q) + 32'(c_q);
`endif

    assign full = base_q + offs;
    assign oor  = (full >= DP);

    // Tile context and walk counters; r is the fast counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            r_q    <= '0;
            c_q    <= '0;
            err_q  <= 1'b0;
`ifdef WADDR_TRANSPOSE_EN
            tr_q   <= 1'b0;
`endif
        end else if (accept) begin
            base_q <= base_d;
            r_q    <= '0;
            c_q    <= '0;
            err_q  <= 1'b0;
`ifdef WADDR_TRANSPOSE_EN
            tr_q   <= transpose;
`endif
        end else begin
            if (addr_valid && oor) begin
                err_q <= 1'b1;
            end
            if (hs) begin
                if (r_end) begin
                    r_q <= '0;
                    c_q <= c_end ? '0 : c_q + TW'(1);
                end else begin
                    r_q <= r_q + TW'(1);
                end
            end
        end
    end

    // Decoded from registered state only; the current out-of-range beat
    // raises err in the same cycle it is presented.
    assign addr = addr_valid ? full[AW-1:0] : '0;
    assign last = addr_valid && r_end && c_end;
    assign err  = err_q || (addr_valid && oor);

endmodule

// File: tb/tb_weight_addr_gen.sv
// Testbench for weight_addr_gen: two instances (DEPTH=1024 and default 32)
// checked every cycle against a beat-index model plus literal sequences.

module tb_weight_addr_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       addr_ready = 1'b0;
    logic [7:0] i = '0;
    logic [7:0] j = '0;
    logic [7:0] k = '0;
`ifdef WADDR_TRANSPOSE_EN
    logic       tr_in = 1'b0;
`endif

    logic       av_a, last_a, busy_a, done_a, err_a;
    logic [9:0] addr_a;
    logic       av_b, last_b, busy_b, done_b, err_b;
    logic [4:0] addr_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    weight_addr_gen #(
        .ROW_STRIDE(16),
        .DEPTH(1024),
        .TILE(4),
        .IDX_W(8)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .start(start),
        .i(i),
        .j(j),
        .k(k),
`ifdef WADDR_TRANSPOSE_EN
        .transpose(tr_in),
`endif
        .addr_ready(addr_ready),
        .addr_valid(av_a),
        .addr(addr_a),
        .last(last_a),
        .busy(busy_a),
        .done(done_a),
        .err(err_a)
    );

    weight_addr_gen dut_b (
        .clk(clk),
        .rst(rst),
        .start(start),
        .i(i),
        .j(j),
        .k(k),
`ifdef WADDR_TRANSPOSE_EN
        .transpose(tr_in),
`endif
        .addr_ready(addr_ready),
        .addr_valid(av_b),
        .addr(addr_b),
        .last(last_b),
        .busy(busy_b),
        .done(done_b),
        .err(err_b)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 streaming, 2 done; n is the beat index.
    int          ph = 0;
    int          n = 0;
    int unsigned mbase = 0;
    bit          mtr = 1'b0;
    bit          merr0 = 1'b0;
    bit          merr1 = 1'b0;

    function automatic int unsigned mfull(input int nn);
        if (mtr) return mbase + 16 * (nn / 4) + (nn % 4);
        return mbase + 16 * (nn % 4) + (nn / 4);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph    <= 0;
            n     <= 0;
            merr0 <= 1'b0;
            merr1 <= 1'b0;
        end else begin
            case (ph)
                0: if (start) begin
                    ph    <= 1;
                    n     <= 0;
                    mbase <= 64 * i * k + 4 * j;
`ifdef WADDR_TRANSPOSE_EN
                    mtr   <= tr_in;
`endif
                    merr0 <= 1'b0;
                    merr1 <= 1'b0;
                end
                1: begin
                    if (mfull(n) >= 1024) merr0 <= 1'b1;
                    if (mfull(n) >= 32) merr1 <= 1'b1;
                    if (addr_ready) begin
                        n <= n + 1;
                        if (n == 15) ph <= 2;
                    end
                end
                default: ph <= 0;
            endcase
        end
    end

    logic        m_run;
    int unsigned m_f;
    int unsigned cap[$];
    int          nlast = 0;
    int unsigned last_addr = 0;

    always @(negedge clk) begin
        m_run = (ph == 1);
        m_f   = mfull(n);
        chk("valid_a", 32'(av_a), 32'(m_run));
        chk("addr_a", 32'(addr_a), m_run ? m_f % 1024 : 0);
        chk("last_a", 32'(last_a), 32'(m_run && n == 15));
        chk("busy_a", 32'(busy_a), 32'(m_run));
        chk("done_a", 32'(done_a), 32'(ph == 2));
        chk("err_a", 32'(err_a), 32'(merr0 || (m_run && m_f >= 1024)));
        chk("valid_b", 32'(av_b), 32'(m_run));
        chk("addr_b", 32'(addr_b), m_run ? m_f % 32 : 0);
        chk("last_b", 32'(last_b), 32'(m_run && n == 15));
        chk("busy_b", 32'(busy_b), 32'(m_run));
        chk("done_b", 32'(done_b), 32'(ph == 2));
        chk("err_b", 32'(err_b), 32'(merr1 || (m_run && m_f >= 32)));
        if (av_a && addr_ready) begin
            cap.push_back(32'(addr_a));
            if (last_a) begin
                nlast++;
                last_addr = 32'(addr_a);
            end
        end
    end

    int unsigned EXP_N[16] = '{72, 88, 104, 120, 73, 89, 105, 121,
                               74, 90, 106, 122, 75, 91, 107, 123};
`ifdef WADDR_TRANSPOSE_EN
    int unsigned EXP_T[16] = '{72, 73, 74, 75, 88, 89, 90, 91,
                               104, 105, 106, 107, 120, 121, 122, 123};
`endif

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_tile(input logic [7:0] ii, input logic [7:0] jj,
                              input logic [7:0] kk);
        cap.delete();
        nlast = 0;
        i = ii;
        j = jj;
        k = kk;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (!done_a && t < 60) begin
            tick();
            t++;
        end
        chk(nm, 32'(done_a), 32'd1);
    endtask

    task automatic cmp_seq(input string nm, input int unsigned e[16]);
        chk({nm, "_count"}, 32'(cap.size()), 32'd16);
        for (int x = 0; x < 16; x++) begin
            chk(nm, x < cap.size() ? cap[x] : 32'hFFFF_FFFF, e[x]);
        end
        chk({nm, "_nlast"}, 32'(nlast), 32'd1);
        chk({nm, "_lastaddr"}, last_addr, e[15]);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", 32'(av_a), 0);
        chk("rst_addr", 32'(addr_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_err", 32'(err_b), 0);
        rst = 1'b0;
        addr_ready = 1'b1;
        tick();

        // Full tile, ready held high
        start_tile(8'd1, 8'd2, 8'd1);
        chk("first_addr", 32'(addr_a), 32'd72);
        chk("first_busy", 32'(busy_a), 32'd1);
        wait_done("done_t1");
        chk("done_busy", 32'(busy_a), 32'd0);
        chk("done_err_a", 32'(err_a), 32'd0);
        cmp_seq("seq_t1", EXP_N);
        tick();
        chk("done_pulse_1cyc", 32'(done_a), 32'd0);

        // Stall for three cycles on the third beat
        start_tile(8'd1, 8'd2, 8'd1);
        for (int t = 0; t < 20 && addr_a != 10'd104; t++) tick();
        addr_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("stall_addr", 32'(addr_a), 32'd104);
            chk("stall_valid", 32'(av_a), 32'd1);
        end
        addr_ready = 1'b1;
        wait_done("done_stall");
        cmp_seq("seq_stall", EXP_N);
        tick();

        // Out-of-range tile on the 32-word instance
        start_tile(8'd1, 8'd0, 8'd1);
        chk("oor_err_first", 32'(err_b), 32'd1);
        chk("oor_addr_first", 32'(addr_b), 32'd0);
        wait_done("done_oor");
        chk("oor_err_done", 32'(err_b), 32'd1);
        tick();
        chk("oor_err_sticky", 32'(err_b), 32'd1);
        start_tile(8'd0, 8'd0, 8'd0);
        chk("oor_err_cleared", 32'(err_b), 32'd0);
        wait_done("done_base0");
        tick();

        // Reset in the middle of a tile
        start_tile(8'd1, 8'd2, 8'd1);
        repeat (5) tick();
        chk("beat5_addr", 32'(addr_a), 32'd89);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(av_a), 0);
        chk("mid_rst_addr", 32'(addr_a), 0);
        chk("mid_rst_busy", 32'(busy_a), 0);
        chk("mid_rst_last", 32'(last_a), 0);
        tick();
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("no_done_after_rst", 32'(done_a), 0);
        end
        start_tile(8'd1, 8'd2, 8'd1);
        wait_done("done_after_rst");
        cmp_seq("seq_after_rst", EXP_N);

        // start pulses during DONE and RUN are ignored
        start = 1'b1;
        i = 8'd3;
        j = 8'd5;
        tick();
        start = 1'b0;
        chk("ign_done_busy", 32'(busy_a), 0);
        tick();
        start_tile(8'd1, 8'd2, 8'd1);
        repeat (3) tick();
        i = 8'd3;
        j = 8'd5;
        k = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("done_ign");
        cmp_seq("seq_ign", EXP_N);
        tick();

`ifdef WADDR_TRANSPOSE_EN
        tr_in = 1'b1;
        start_tile(8'd1, 8'd2, 8'd1);
        tr_in = 1'b0;
        wait_done("done_tr");
        cmp_seq("seq_tr", EXP_T);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
